// File: rtl/fetch_pkg.sv
// Shared fetch-path constants and the prefetch queue entry type.
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Registered synchronous queue of fetched {pc, instr} entries with flush.
module prefetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  fetch_entry_t               wdata,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: sequential fetch into a queue feeding decode.
// Optional PREFETCH_BYPASS_EN offers a response directly when the queue is empty.
module instr_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_redirect_valid,
    input  logic [31:0]                i_redirect_pc,
    output logic                       o_imem_rd_en,
    output logic [31:0]                o_imem_rd_addr,
    input  logic [31:0]                i_imem_rd_data,
    output logic                       o_dec_valid,
    output logic [31:0]                o_dec_instr,
    output logic [31:0]                o_dec_pc,
    input  logic                       i_dec_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q;
    logic            inflight_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic            issue;
    logic            bypass;
    logic            fifo_push;
    logic            fifo_pop;
    fetch_entry_t    fifo_wdata;
    fetch_entry_t    fifo_head;
    logic [CW-1:0]   fifo_count;

    // Reserving a slot for the in-flight response keeps the queue from overflowing.
    assign issue = !rst && !i_redirect_valid
                   && ((32'(fifo_count) + 32'(inflight_q)) < DEPTH);

`ifdef PREFETCH_BYPASS_EN
    assign bypass = inflight_q && !rst && !i_redirect_valid && (fifo_count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign fifo_wdata = '{pc: inflight_pc_q, instr: i_imem_rd_data};

    always_comb begin
        o_dec_valid = 1'b0;
        o_dec_instr = '0;
        o_dec_pc    = '0;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        if (!rst && !i_redirect_valid) begin
            fifo_push = inflight_q;
            if (bypass) begin
                o_dec_valid = 1'b1;
                o_dec_instr = i_imem_rd_data;
                o_dec_pc    = inflight_pc_q;
                fifo_push   = !i_dec_ready;
            end else if (fifo_count != '0) begin
                o_dec_valid = 1'b1;
                o_dec_instr = fifo_head.instr;
                o_dec_pc    = fifo_head.pc;
                fifo_pop    = i_dec_ready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (i_redirect_valid) begin
            fetch_pc_q <= align_pc(i_redirect_pc);
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= fetch_pc_q;
                fetch_pc_q    <= fetch_pc_q + XLEN'(INSTR_BYTES);
            end
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (i_redirect_valid),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign o_imem_rd_en   = issue;
    assign o_imem_rd_addr = fetch_pc_q;
    // The queue is logically empty during reset and in a flushing cycle.
    assign o_count        = (rst || i_redirect_valid) ? '0 : fifo_count;

endmodule

// File: doc/instr_prefetch_buffer.md
INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, minimum 2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch byte address after reset.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port i_redirect_valid  input  1  meaning flush and restart fetch (branch/jump taken).
REQ-006 SHALL have port i_redirect_pc  input  32  meaning redirect target byte address.
REQ-007 SHALL have port o_imem_rd_en  output  1  meaning instruction memory read request this cycle.
REQ-008 SHALL have port o_imem_rd_addr  output  32  meaning byte address of the request.
REQ-009 SHALL have port i_imem_rd_data  input  32  meaning read word, valid exactly 1 cycle after o_imem_rd_en.
REQ-010 SHALL have port o_dec_valid  output  1  meaning an instruction is offered to decode.
REQ-011 SHALL have port o_dec_instr  output  32  meaning the offered instruction word.
REQ-012 SHALL have port o_dec_pc  output  32  meaning the byte address of o_dec_instr.
REQ-013 SHALL have port i_dec_ready  input  1  meaning decode accepts the offered instruction.
REQ-014 SHALL have port o_count  output  $clog2(DEPTH+1)  meaning current queue occupancy.

Function
REQ-015 SHALL keep fetch_pc; o_imem_rd_addr = fetch_pc; fetch_pc += 4 on each issue, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-016 SHALL assert o_imem_rd_en only when !rst, !i_redirect_valid, and (count + inflight) < DEPTH (inflight = request issued last cycle).
REQ-017 SHALL push {fetch address, i_imem_rd_data} into the queue in the cycle after an issue, unless that cycle has i_redirect_valid.
REQ-018 SHALL drive o_dec_valid = (count != 0) && !i_redirect_valid, with o_dec_instr/o_dec_pc from the queue head.
REQ-019 SHALL pop the head when o_dec_valid && i_dec_ready; o_dec_* SHALL be held stable while o_dec_valid && !i_dec_ready.
REQ-020 SHALL support a push and a pop in the same cycle with count unchanged; overflow SHALL be impossible by construction of REQ-016.
REQ-021 SHALL sustain 1 instruction/cycle with i_dec_ready held high, after the initial 2-cycle fill latency (issue -> push -> offer).
REQ-022 On i_redirect_valid: count <= 0, in-flight response discarded, no issue that cycle, fetch_pc <= {i_redirect_pc[31:2], 2'b00}; first issue on the next cycle.
REQ-023 Back-to-back redirects SHALL each take effect; the last one defines fetch_pc.
REQ-024 With the queue empty, o_dec_valid SHALL be 0 and i_dec_ready SHALL be ignored.

Reset
REQ-025 On rst: fetch_pc <= RESET_PC, count <= 0, inflight <= 0, read/write pointers <= 0.
REQ-026 During rst: o_imem_rd_en = 0, o_dec_valid = 0, o_dec_instr = 0, o_dec_pc = 0, o_count = 0; first issue in the cycle after rst deasserts.
REQ-027 Reset mid-operation SHALL discard queue contents and any in-flight response.

Configuration
REQ-028 Macro PREFETCH_BYPASS_EN SHALL be used as follows: defined, when count == 0 and a response arrives, o_dec_valid = 1 in the response cycle with o_dec_instr = i_imem_rd_data; if accepted, no push occurs; fill latency = 1 cycle.
REQ-029 Without PREFETCH_BYPASS_EN, every instruction SHALL pass through the queue; fill latency = 2 cycles.

Structure
REQ-030 Shared package fetch_pkg SHALL hold XLEN = 32, INSTR_BYTES = 4, and the queue entry typedef {pc[31:0], instr[31:0]}.
REQ-031 The queue SHALL be a sub-module prefetch_fifo (synchronous, registered, DEPTH entries, push/pop/count).

Verification
REQ-032 Reset release, memory returns addr>>2, ready high -> addresses 0,4,8,... issued; o_dec_pc 0 in cycle 2, then +4 every cycle.
REQ-033 Ready low for 10 cycles -> o_count saturates at 4, o_imem_rd_en low, head held at pc 0; ready high -> pcs 0,4,8,12,16 in order, no gap or duplicate.
REQ-034 Redirect to 32'h0000_0103 with 3 entries queued -> o_dec_valid 0 that cycle, o_count 0; next issue at 32'h0000_0100; the stale response is not delivered.
REQ-035 RESET_PC = 32'hFFFF_FFF8, ready high -> delivered pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 With PREFETCH_BYPASS_EN, empty queue, ready high -> instruction offered in the response cycle (latency 1), and o_count stays 0.
